// File: rtl/wt_hybrid_cache_pkg.sv
// Shared types and constants for the hybrid write-through D-cache.
package wt_hybrid_cache_pkg;

  localparam int unsigned MISS_ARB_DEFAULT_PORTS = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    MFLUSH = 2'd3
  } miss_arb_state_e;

endpackage

// File: rtl/wt_hybche_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr_i, cyclically.
module wt_hybche_rr_pick #(
  parameter int unsigned NUM_PORTS = 3,
  localparam int unsigned IDX_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic                 valid_o,
  output logic [IDX_W-1:0]     idx_o
);

  localparam int unsigned POS_W = $clog2(2 * NUM_PORTS);

  logic [NUM_PORTS-1:0]   mask;
  logic [2*NUM_PORTS-1:0] dbl;
  logic [POS_W-1:0]       pos;

  // Lower half holds requests at/after ptr, upper half the full vector, so the
  // lowest set bit of the doubled vector is the cyclic winner.
  always_comb begin
    mask    = '0;
    valid_o = 1'b0;
    pos     = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      mask[i] = (i >= int'(ptr_i));
    end
    dbl = {req_i, req_i & mask};
    for (int i = 2 * int'(NUM_PORTS) - 1; i >= 0; i--) begin
      if (dbl[i]) begin
        valid_o = 1'b1;
        pos     = POS_W'(i);
      end
    end
    idx_o = (pos >= POS_W'(NUM_PORTS)) ? IDX_W'(pos - POS_W'(NUM_PORTS)) : IDX_W'(pos);
  end

endmodule

// File: rtl/wt_hybche_miss_arb.sv
// Round-robin arbiter/sequencer in front of the miss unit, with mode-flush
// serialisation against in-flight misses.
module wt_hybche_miss_arb
  import wt_hybrid_cache_pkg::*;
#(
  parameter int unsigned NUM_PORTS = MISS_ARB_DEFAULT_PORTS,
  parameter int unsigned PLEN      = 56
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_PORTS-1:0]           req_i,
  input  logic [NUM_PORTS-1:0]           nc_i,
  input  logic [NUM_PORTS-1:0][PLEN-1:0] addr_i,
  output logic [NUM_PORTS-1:0]           gnt_o,
  output logic [NUM_PORTS-1:0]           done_o,
  input  logic                           mode_change_i,
  output logic                           mode_flush_req_o,
  input  logic                           mode_flush_ack_i,
  output logic                           mode_busy_o,
  output logic                           miss_req_o,
  input  logic                           miss_ack_i,
  output logic                           miss_nc_o,
  output logic [PLEN-1:0]                miss_addr_o,
  input  logic                           miss_busy_i
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);

  miss_arb_state_e  state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PLEN-1:0]  addr_q, addr_d;
  logic             nc_q, nc_d;
  logic             pend_q, pend_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  wt_hybche_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Next state and outputs; a mode change arriving with the flush ack re-arms pend.
  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    idx_d            = idx_q;
    addr_d           = addr_q;
    nc_d             = nc_q;
    pend_d           = pend_q | mode_change_i;
    gnt_o            = '0;
    done_o           = '0;
    miss_req_o       = 1'b0;
    miss_nc_o        = 1'b0;
    miss_addr_o      = '0;
    mode_flush_req_o = 1'b0;
    mode_busy_o      = pend_q | (state_q == MFLUSH);
    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = MFLUSH;
        end else if (pick_valid) begin
          idx_d   = pick_idx;
          addr_d  = addr_i[pick_idx];
          nc_d    = nc_i[pick_idx];
          state_d = REQ;
        end
      end
      REQ: begin
        miss_req_o  = 1'b1;
        miss_addr_o = addr_q;
        miss_nc_o   = nc_q;
        if (miss_ack_i) begin
          gnt_o[idx_q] = 1'b1;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (!miss_busy_i) begin
          done_o[idx_q] = 1'b1;
          ptr_d         = (idx_q == IDX_W'(NUM_PORTS - 1)) ? '0 : idx_q + 1'b1;
          state_d       = IDLE;
        end
      end
      MFLUSH: begin
        mode_flush_req_o = 1'b1;
        if (mode_flush_ack_i) begin
          if (!mode_change_i) pend_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      nc_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      nc_q    <= nc_d;
      pend_q  <= pend_d;
    end
  end

  // Selected requester must hold its request until granted.
  a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == REQ) |-> req_i[idx_q]);
  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
  a_done_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(done_o));

endmodule
